// File: rtl/mips_pkg.sv
// Shared widths, constants and types for the MIPS pipeline datapath.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_array.sv
// Storage for registers 1..2^ADDR_W-1: one write port, two raw async read ports, async clear.
module reg_array
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int DEPTH = 1 << ADDR_W;

   // Entry 0 has no storage; address 0 simply matches no entry.
   logic [DATA_W-1:0] mem [1:DEPTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (we && (waddr == ADDR_W'(i))) mem[i] <= wdata;
         end
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (raddr_a == ADDR_W'(i)) rdata_a = mem[i];
         if (raddr_b == ADDR_W'(i)) rdata_b = mem[i];
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: result mux, architectural register file with
// write-to-read bypass and $zero forcing, and a retired-write counter.
module wb_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_WB_register_write,
   input  logic              MEM_WB_memory_to_register,
   input  logic [ADDR_W-1:0] MEM_WB_register_write_address,
   input  logic [DATA_W-1:0] MEM_WB_read_data,
   input  logic [DATA_W-1:0] MEM_WB_alu_result,
   input  logic [ADDR_W-1:0] ID_rs_address,
   input  logic [ADDR_W-1:0] ID_rt_address,
   output logic [DATA_W-1:0] ID_rs_data,
   output logic [DATA_W-1:0] ID_rt_data,
   output logic [DATA_W-1:0] WB_write_data,
   output logic [31:0]       WB_retire_count
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic              commit;
   logic [DATA_W-1:0] raw_rs;
   logic [DATA_W-1:0] raw_rt;

   assign WB_write_data = MEM_WB_memory_to_register ? MEM_WB_read_data : MEM_WB_alu_result;

   // Reset gates the commit so the bypass also reads zero while rst is high.
   assign commit = MEM_WB_register_write && (MEM_WB_register_write_address != ZERO_ADDR) && !rst;

   reg_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_reg_array (
      .clk     (clk),
      .rst     (rst),
      .we      (commit),
      .waddr   (MEM_WB_register_write_address),
      .wdata   (WB_write_data),
      .raddr_a (ID_rs_address),
      .raddr_b (ID_rt_address),
      .rdata_a (raw_rs),
      .rdata_b (raw_rt)
   );

   always_comb begin
      ID_rs_data = raw_rs;
      ID_rt_data = raw_rt;
      if (ID_rs_address == ZERO_ADDR) begin
         ID_rs_data = '0;
      end else if (commit && (ID_rs_address == MEM_WB_register_write_address)) begin
         ID_rs_data = WB_write_data;
      end
      if (ID_rt_address == ZERO_ADDR) begin
         ID_rt_data = '0;
      end else if (commit && (ID_rt_address == MEM_WB_register_write_address)) begin
         ID_rt_data = WB_write_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_retire_count <= '0;
      end else if (commit) begin
         WB_retire_count <= WB_retire_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus random traffic
// checked against an array-based model of the architectural registers.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        reg_write;
   logic        mem_to_reg;
   logic [4:0]  waddr;
   logic [31:0] read_data;
   logic [31:0] alu_result;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data;
   logic [31:0] retire_count;

   typedef struct {
      int          id;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] wb;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_regs [32];
   logic [31:0] model_count;
   int          n_compared = 0;
   int          n_failed   = 0;
   int          cycle_id   = 0;

   wb_regfile dut (
      .clk                           (clk),
      .rst                           (rst),
      .MEM_WB_register_write         (reg_write),
      .MEM_WB_memory_to_register     (mem_to_reg),
      .MEM_WB_register_write_address (waddr),
      .MEM_WB_read_data              (read_data),
      .MEM_WB_alu_result             (alu_result),
      .ID_rs_address                 (rs_addr),
      .ID_rt_address                 (rt_addr),
      .ID_rs_data                    (rs_data),
      .ID_rt_data                    (rt_data),
      .WB_write_data                 (wb_data),
      .WB_retire_count               (retire_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int id,
                              input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_failed++;
         $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, id, act, exp);
      end
   endtask

   // Monitor: consumes one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checkOutput("rs_data", e.id, rs_data, e.rs);
         checkOutput("rt_data", e.id, rt_data, e.rt);
         checkOutput("wb_data", e.id, wb_data, e.wb);
         checkOutput("retire_count", e.id, retire_count, e.cnt);
      end
   end

   function automatic logic [31:0] modelRead(input logic [4:0] a, input logic do_commit,
                                             input logic [4:0] wa, input logic [31:0] wv);
      if (a == 5'd0) return 32'd0;
      if (do_commit && a == wa) return wv;
      return model_regs[a];
   endfunction

   function automatic void modelClear();
      foreach (model_regs[i]) model_regs[i] = 32'd0;
      model_count = 32'd0;
   endfunction

   function automatic void pushExpect();
      exp_t        e;
      logic [31:0] wv;
      logic        do_commit;
      wv        = mem_to_reg ? read_data : alu_result;
      do_commit = reg_write && (waddr != 5'd0) && !rst;
      e.id  = cycle_id;
      e.rs  = modelRead(rs_addr, do_commit, waddr, wv);
      e.rt  = modelRead(rt_addr, do_commit, waddr, wv);
      e.wb  = wv;
      e.cnt = model_count;
      exp_q.push_back(e);
   endfunction

   // Called just after a rising edge: drives one cycle, expects, then commits the model.
   task automatic applyStimulus(input logic we, input logic m2r, input logic [4:0] wa,
                                input logic [31:0] rd, input logic [31:0] alu,
                                input logic [4:0] rs, input logic [4:0] rt);
      logic [31:0] wv;
      logic        do_commit;
      reg_write  = we;
      mem_to_reg = m2r;
      waddr      = wa;
      read_data  = rd;
      alu_result = alu;
      rs_addr    = rs;
      rt_addr    = rt;
      pushExpect();
      wv        = m2r ? rd : alu;
      do_commit = we && (wa != 5'd0) && !rst;
      @(posedge clk);
      #1;
      cycle_id++;
      if (do_commit) begin
         model_regs[wa] = wv;
         model_count    = model_count + 32'd1;
      end
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      modelClear();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic [4:0]  a;
      rst = 1'b0;
      reg_write = 1'b0; mem_to_reg = 1'b0; waddr = '0;
      read_data = '0; alu_result = '0; rs_addr = '0; rt_addr = '0;
      modelClear();
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // All registers read zero after reset.
      for (int i = 0; i < 32; i++)
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));

      // ALU write with same-cycle bypass, then stored.
      applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 32'h1234ABCD, 5'd5, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);

      // Writes to r0 are dropped and not counted.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

      // Load path: enable off, then on with both ports bypassing.
      applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEAD0001, 32'h0BAD0BAD, 5'd7, 5'd7);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hDEAD0001, 32'h0BAD0BAD, 5'd7, 5'd7);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);

      // Fill r1..r31 after a fresh reset, then read back in pairs.
      pulseReset();
      for (int i = 1; i < 32; i++)
         applyStimulus(1'b1, 1'b0, 5'(i), 32'h0, 32'(i) * 32'h01010101, 5'd0, 5'd0);
      for (int i = 0; i < 32; i += 2)
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(i + 1));

      // Random traffic, biased so reads often hit the write address.
      for (int n = 0; n < 400; n++) begin
         a = 5'($urandom_range(0, 31));
         v = $urandom();
         applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, v, $urandom(),
                       ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
      end

      // Reset asserted mid-cycle while writing r9: write lost, outputs zero at once.
      reg_write = 1'b1; mem_to_reg = 1'b0; waddr = 5'd9;
      read_data = 32'h0; alu_result = 32'hCAFEF00D; rs_addr = 5'd9; rt_addr = 5'd9;
      #2;
      rst = 1'b1;
      modelClear();
      pushExpect();
      @(posedge clk); #1;
      cycle_id++;
      applyStimulus(1'b1, 1'b0, 5'd9, 32'h0, 32'h55AA55AA, 5'd9, 5'd3);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h600DF00D, 32'h0, 5'd9, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd1);

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_compared++;
         n_failed++;
         $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
